mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Two-lane load/store request bus plus the single data-memory port it is arbitrated onto.
// The master side belongs to the requesters and the memory; the slave side belongs to the arbiter.
interface mem_port_arbiter_if;
  logic        req0;
  logic        req1;
  logic        st0;
  logic        st1;
  logic [4:0]  addr0;
  logic [4:0]  addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic [2:0]  tag0;
  logic [2:0]  tag1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] ld_data;
  logic [18:0] rd_val;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport master (
    output req0, req1, st0, st1, addr0, addr1, wdata0, wdata1, tag0, tag1, mem_rdata,
    input  gnt0, gnt1, done0, done1, ld_data, rd_val, mem_en, mem_we, mem_addr,
           mem_wdata, busy
  );

  modport slave (
    input  req0, req1, st0, st1, addr0, addr1, wdata0, wdata1, tag0, tag1, mem_rdata,
    output gnt0, gnt1, done0, done1, ld_data, rd_val, mem_en, mem_we, mem_addr,
           mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter putting two load/store lanes onto one 32x16 synchronous-read memory port.
// Stores complete in one cycle; loads spend one cycle in LD_WAIT for the read data.
//
//   state   | meaning
//   IDLE    | grants allowed; a store grant stays here, a load grant moves to LD_WAIT
//   LD_WAIT | read data in flight; no grants; capture data and tag, pulse done, back to IDLE
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        ptr_q;
  logic        ptr_d;
  logic        conflict;
  logic        gnt_any;
  logic        sel1;
  logic        g_st;
  logic [4:0]  g_addr;
  logic [15:0] g_wdata;
  logic [2:0]  g_tag;
  logic        pend_lane_q;
  logic [2:0]  pend_tag_q;
  logic        done0_q;
  logic        done1_q;
  logic [15:0] ld_data_q;
  logic [2:0]  rd_tag_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_any  = 1'b0;
    sel1     = 1'b0;
    // A store and another access to the same word keep program order: lane 0 goes first.
    conflict = bus.req0 & bus.req1 & (bus.addr0 == bus.addr1) & (bus.st0 | bus.st1);

    if (rst_n && (state_q == IDLE)) begin
      if (bus.req0 && bus.req1) begin
        gnt_any = 1'b1;
        sel1    = conflict ? 1'b0 : ptr_q;
      end else if (bus.req0 || bus.req1) begin
        gnt_any = 1'b1;
        sel1    = bus.req1;
      end
    end

    g_st    = sel1 ? bus.st1    : bus.st0;
    g_addr  = sel1 ? bus.addr1  : bus.addr0;
    g_wdata = sel1 ? bus.wdata1 : bus.wdata0;
    g_tag   = sel1 ? bus.tag1   : bus.tag0;

    if (gnt_any) begin
      ptr_d = ~sel1;
      if (!g_st) begin
        state_d = LD_WAIT;
      end
    end

    if (state_q == LD_WAIT) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      pend_lane_q <= 1'b0;
      pend_tag_q  <= 3'd0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      ld_data_q   <= 16'd0;
      rd_tag_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done0_q <= gnt_any & g_st & ~sel1;
      done1_q <= gnt_any & g_st & sel1;
      if (gnt_any && !g_st) begin
        pend_lane_q <= sel1;
        pend_tag_q  <= g_tag;
      end
      // No grant is possible in LD_WAIT, so the load's done cannot collide with a store's.
      if (state_q == LD_WAIT) begin
        ld_data_q <= bus.mem_rdata;
        rd_tag_q  <= pend_tag_q;
        done0_q   <= ~pend_lane_q;
        done1_q   <= pend_lane_q;
      end
    end
  end

  assign bus.gnt0      = gnt_any & ~sel1;
  assign bus.gnt1      = gnt_any & sel1;
  assign bus.mem_en    = gnt_any;
  assign bus.mem_we    = gnt_any & g_st;
  assign bus.mem_addr  = gnt_any ? g_addr : 5'd0;
  assign bus.mem_wdata = (gnt_any && g_st) ? g_wdata : 16'd0;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.ld_data   = ld_data_q;
  assign bus.rd_val    = {ld_data_q, rd_tag_q};
  assign bus.busy      = (state_q == LD_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a grant-decision vector table plus
// cycle-by-cycle sequences for loads, stores, ordering, fairness and reset mid-load.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model with a backdoor write port for preloading.
  logic [15:0] mem [32];
  logic        bk_we;
  logic [4:0]  bk_addr;
  logic [15:0] bk_data;

  always @(posedge clk) begin
    if (bk_we) begin
      mem[bk_addr] <= bk_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.st0 = 1'b0;   bus.st1 = 1'b0;
    bus.addr0 = 5'd0; bus.addr1 = 5'd0;
    bus.wdata0 = 16'd0; bus.wdata1 = 16'd0;
    bus.tag0 = 3'd0;  bus.tag1 = 3'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    step();
    bk_we = 1'b0;
  endtask

  // Single lane-0 store so the round-robin pointer ends up on lane 1.
  task automatic prime_ptr1();
    bus.req0 = 1'b1; bus.st0 = 1'b1; bus.addr0 = 5'd31; bus.wdata0 = 16'd0;
    @(negedge clk);
    chk("prime_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    clear_reqs();
  endtask

  typedef struct {
    logic [4:0]  ctl;     // {ptr1, req0, req1, st0, st1}
    logic [4:0]  addr0;
    logic [4:0]  addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [3:0]  exp;     // {gnt0, gnt1, mem_en, mem_we}
    logic [4:0]  eaddr;
    logic [15:0] ewdata;
  } vec_t;

  typedef struct {
    logic        lane;
    logic [2:0]  tag;
    logic [15:0] data;
  } exp_t;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    exp_t sbq[$];
    exp_t e;
    int n0, n1, ngnt, ndone, last_g, cyc;
    logic lane;

    total = 0;
    bad   = 0;
    bk_we = 1'b0; bk_addr = 5'd0; bk_data = 16'd0;

    vecs[0]  = '{5'b01000, 5'd3,  5'd0,  16'hA000, 16'hB000, 4'b1010, 5'd3,  16'h0000};
    vecs[1]  = '{5'b00101, 5'd0,  5'd9,  16'hA001, 16'hB001, 4'b0111, 5'd9,  16'hB001};
    vecs[2]  = '{5'b01100, 5'd1,  5'd2,  16'hA002, 16'hB002, 4'b1010, 5'd1,  16'h0000};
    vecs[3]  = '{5'b11100, 5'd1,  5'd2,  16'hA003, 16'hB003, 4'b0110, 5'd2,  16'h0000};
    vecs[4]  = '{5'b11110, 5'd4,  5'd4,  16'hA004, 16'hB004, 4'b1011, 5'd4,  16'hA004};
    vecs[5]  = '{5'b11101, 5'd6,  5'd6,  16'hA005, 16'hB005, 4'b1010, 5'd6,  16'h0000};
    vecs[6]  = '{5'b11100, 5'd8,  5'd8,  16'hA006, 16'hB006, 4'b0110, 5'd8,  16'h0000};
    vecs[7]  = '{5'b11111, 5'd10, 5'd11, 16'hA007, 16'hB007, 4'b0111, 5'd11, 16'hB007};
    vecs[8]  = '{5'b00011, 5'd3,  5'd3,  16'hA008, 16'hB008, 4'b0000, 5'd0,  16'h0000};
    vecs[9]  = '{5'b11010, 5'd12, 5'd13, 16'hA009, 16'hB009, 4'b1011, 5'd12, 16'hA009};
    vecs[10] = '{5'b11111, 5'd14, 5'd14, 16'hA00A, 16'hB00A, 4'b1011, 5'd14, 16'hA00A};

    // Reset: outputs quiet even with requests pending.
    rst_n = 1'b0;
    clear_reqs();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.st0 = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_gnt0",    32'(bus.gnt0),    32'd0);
    chk("rst_gnt1",    32'(bus.gnt1),    32'd0);
    chk("rst_mem_en",  32'(bus.mem_en),  32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
    chk("rst_done0",   32'(bus.done0),   32'd0);
    chk("rst_done1",   32'(bus.done1),   32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_ld_data", 32'(bus.ld_data), 32'd0);
    chk("rst_rd_val",  32'(bus.rd_val),  32'd0);
    clear_reqs();

    // Grant decision table.
    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].ctl[4]) prime_ptr1();
      {bus.req0, bus.req1, bus.st0, bus.st1} = vecs[i].ctl[3:0];
      bus.addr0 = vecs[i].addr0;   bus.addr1 = vecs[i].addr1;
      bus.wdata0 = vecs[i].wdata0; bus.wdata1 = vecs[i].wdata1;
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i),   32'(bus.gnt0),   32'(vecs[i].exp[3]));
      chk($sformatf("v%0d_gnt1", i),   32'(bus.gnt1),   32'(vecs[i].exp[2]));
      chk($sformatf("v%0d_mem_en", i), 32'(bus.mem_en), 32'(vecs[i].exp[1]));
      chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp[0]));
      if (vecs[i].exp[1]) begin
        chk($sformatf("v%0d_mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].eaddr));
        chk($sformatf("v%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].ewdata));
      end
      step();
      clear_reqs();
      repeat (3) step();
    end

    // Single load, a store waiting through LD_WAIT, grant alongside the load's done.
    preload(5'd5, 16'h1234);
    do_reset();
    bus.req0 = 1'b1; bus.st0 = 1'b0; bus.addr0 = 5'd5; bus.tag0 = 3'd3;
    @(negedge clk);
    chk("ld_gnt0_T", 32'(bus.gnt0), 32'd1);
    chk("ld_busy_T", 32'(bus.busy), 32'd0);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.st1 = 1'b1; bus.addr1 = 5'd20; bus.wdata1 = 16'h5555;
    @(negedge clk);
    chk("ld_busy_T1",   32'(bus.busy),   32'd1);
    chk("ld_done0_T1",  32'(bus.done0),  32'd0);
    chk("ld_gnt1_wait", 32'(bus.gnt1),   32'd0);
    chk("ld_en_wait",   32'(bus.mem_en), 32'd0);
    step();
    @(negedge clk);
    chk("ld_done0_T2",   32'(bus.done0),   32'd1);
    chk("ld_busy_T2",    32'(bus.busy),    32'd0);
    chk("ld_data_T2",    32'(bus.ld_data), 32'h1234);
    chk("ld_rd_val_T2",  32'(bus.rd_val),  32'h091A3);
    chk("ld_gnt1_T2",    32'(bus.gnt1),    32'd1);
    step();
    clear_reqs();
    @(negedge clk);
    chk("st_done1_T3",   32'(bus.done1),   32'd1);
    chk("st_done0_T3",   32'(bus.done0),   32'd0);
    chk("ld_data_hold",  32'(bus.ld_data), 32'h1234);
    chk("rd_val_hold",   32'(bus.rd_val),  32'h091A3);
    step();
    chk("st_mem20", 32'(mem[20]), 32'h5555);

    // Back-to-back stores from reset.
    do_reset();
    bus.req0 = 1'b1; bus.st0 = 1'b1; bus.addr0 = 5'd2; bus.wdata0 = 16'hAAAA;
    bus.req1 = 1'b1; bus.st1 = 1'b1; bus.addr1 = 5'd7; bus.wdata1 = 16'hBBBB;
    @(negedge clk);
    chk("b2b_gnt0_T", 32'(bus.gnt0), 32'd1);
    chk("b2b_gnt1_T", 32'(bus.gnt1), 32'd0);
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("b2b_gnt1_T1",  32'(bus.gnt1),  32'd1);
    chk("b2b_done0_T1", 32'(bus.done0), 32'd1);
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("b2b_done1_T2", 32'(bus.done1), 32'd1);
    chk("b2b_done0_T2", 32'(bus.done0), 32'd0);
    chk("b2b_ld_data",  32'(bus.ld_data), 32'd0);
    step();
    chk("b2b_mem2", 32'(mem[2]), 32'hAAAA);
    chk("b2b_mem7", 32'(mem[7]), 32'hBBBB);

    // Same-address store/load with pointer on lane 1: store goes first.
    preload(5'd4, 16'hDEAD);
    do_reset();
    prime_ptr1();
    bus.req0 = 1'b1; bus.st0 = 1'b1; bus.addr0 = 5'd4; bus.wdata0 = 16'h00FF;
    bus.req1 = 1'b1; bus.st1 = 1'b0; bus.addr1 = 5'd4; bus.tag1 = 3'd5;
    @(negedge clk);
    chk("cf_gnt0_T", 32'(bus.gnt0), 32'd1);
    chk("cf_gnt1_T", 32'(bus.gnt1), 32'd0);
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("cf_gnt1_T1", 32'(bus.gnt1), 32'd1);
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("cf_busy_T2", 32'(bus.busy), 32'd1);
    step();
    @(negedge clk);
    chk("cf_done1_T3",  32'(bus.done1),   32'd1);
    chk("cf_ld_data",   32'(bus.ld_data), 32'h00FF);
    chk("cf_rd_val",    32'(bus.rd_val),  32'({16'h00FF, 3'd5}));
    step();

    // Fairness: 8 loads per lane to distinct addresses.
    for (int a = 0; a < 8; a++) begin
      preload(5'(a),      16'hC000 | 16'(a));
      preload(5'(16 + a), 16'hC000 | 16'(16 + a));
    end
    do_reset();
    n0 = 0; n1 = 0; ngnt = 0; ndone = 0; last_g = 0; cyc = 0;
    while (ndone < 16 && cyc < 80) begin
      bus.req0 = (n0 < 8); bus.st0 = 1'b0; bus.addr0 = 5'(n0);      bus.tag0 = 3'(n0);
      bus.req1 = (n1 < 8); bus.st1 = 1'b0; bus.addr1 = 5'(16 + n1); bus.tag1 = 3'(7 - n1);
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        chk("fair_one_done", 32'(bus.done0 & bus.done1), 32'd0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fair_spurious_done: got done with no load outstanding, want none");
        end else begin
          e = sbq.pop_front();
          chk($sformatf("fair_done_lane%0d", ndone), 32'(bus.done1),        32'(e.lane));
          chk($sformatf("fair_tag%0d", ndone),       32'(bus.rd_val[2:0]),  32'(e.tag));
          chk($sformatf("fair_data%0d", ndone),      32'(bus.ld_data),      32'(e.data));
        end
        ndone++;
      end
      if (bus.gnt0 || bus.gnt1) begin
        lane = bus.gnt1;
        chk($sformatf("fair_gnt_lane%0d", ngnt), 32'(lane), 32'(ngnt % 2));
        if (ngnt > 0) chk($sformatf("fair_gap%0d", ngnt), 32'(cyc - last_g), 32'd2);
        if (lane == 1'b0) begin
          sbq.push_back('{1'b0, 3'(n0), 16'hC000 | 16'(n0)});
          n0++;
        end else begin
          sbq.push_back('{1'b1, 3'(7 - n1), 16'hC000 | 16'(16 + n1)});
          n1++;
        end
        ngnt++;
        last_g = cyc;
      end
      step();
      cyc++;
    end
    chk("fair_ngnt",  32'(ngnt),  32'd16);
    chk("fair_ndone", 32'(ndone), 32'd16);
    clear_reqs();
    step();

    // Reset in LD_WAIT abandons the load.
    preload(5'd9,  16'hABCD);
    preload(5'd10, 16'h7777);
    preload(5'd12, 16'h1212);
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 5'd9; bus.tag0 = 3'd1;
    @(negedge clk);
    chk("rm_pre_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    bus.req0 = 1'b0;
    step();
    @(negedge clk);
    chk("rm_pre_ld_data", 32'(bus.ld_data), 32'hABCD);
    step();
    bus.req0 = 1'b1; bus.addr0 = 5'd10; bus.tag0 = 3'd4;
    @(negedge clk);
    chk("rm_gnt0_T", 32'(bus.gnt0), 32'd1);
    step();
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    bus.req1 = 1'b1; bus.st1 = 1'b0; bus.addr1 = 5'd12; bus.tag1 = 3'd2;
    @(negedge clk);
    chk("rm_gnt1_in_rst",  32'(bus.gnt1),   32'd0);
    chk("rm_en_in_rst",    32'(bus.mem_en), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_done0",   32'(bus.done0),   32'd0);
    chk("rm_busy",    32'(bus.busy),    32'd0);
    chk("rm_ld_data", 32'(bus.ld_data), 32'd0);
    chk("rm_rd_val",  32'(bus.rd_val),  32'd0);
    chk("rm_gnt1",    32'(bus.gnt1),    32'd1);
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("rm_done0_late", 32'(bus.done0), 32'd0);
    chk("rm_busy_new",   32'(bus.busy),  32'd1);
    step();
    @(negedge clk);
    chk("rm_done1",       32'(bus.done1),   32'd1);
    chk("rm_ld_data_new", 32'(bus.ld_data), 32'h1212);
    chk("rm_rd_val_new",  32'(bus.rd_val),  32'({16'h1212, 3'd2}));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
